// File: rtl/neuron_pkg.sv
// ---------------------------------------------------------------------------
// neuron_pkg
// Shared types and helpers for the neuron MAC stage.
//   state_t  : handshake FSM states of neuron_mac_seq
//   DATA_W   : signed width of activations and weights
//   ACC_W    : signed width of products and the partial sum
//   ACC_MAX / ACC_MIN : clamp limits of the partial sum
//   sat_add  : saturating ACC_W-bit signed add with overflow flag
// ---------------------------------------------------------------------------
package neuron_pkg;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;

    localparam logic signed [ACC_W-1:0] ACC_MAX = 16'sh7FFF;
    localparam logic signed [ACC_W-1:0] ACC_MIN = 16'sh8000;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        MULT = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    // One guard bit is enough to catch overflow of a two-operand add; when
    // the guard and sign bits differ, the guard bit gives the true sign.
    function automatic logic signed [ACC_W-1:0] sat_add(
        input  logic signed [ACC_W-1:0] a,
        input  logic signed [ACC_W-1:0] b,
        output logic                    ovf
    );
        logic signed [ACC_W:0] s;
        s   = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        ovf = s[ACC_W] ^ s[ACC_W-1];
        if (!ovf)
            sat_add = s[ACC_W-1:0];
        else if (s[ACC_W])
            sat_add = ACC_MIN;
        else
            sat_add = ACC_MAX;
    endfunction

endpackage

// File: rtl/neuron_mac_seq_booth.sv
// ---------------------------------------------------------------------------
// seq_booth_mul
// Radix-2 Booth sequential signed multiplier, one iteration per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load a/b and begin (ignored while busy)
//   a, b       : signed DATA_W operands (a = multiplicand, b = multiplier)
//   busy       : iterations in progress
//   done       : 1-cycle pulse during the last iteration cycle
//   p          : signed ACC_W product, final in the cycle after done
// ---------------------------------------------------------------------------
module seq_booth_mul #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic                     busy,
    output logic                     done,
    output logic signed [ACC_W-1:0]  p
);
    import neuron_pkg::*;

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    // The upper half carries one extra bit so that subtracting a
    // multiplicand of -2^(DATA_W-1) cannot wrap.
    logic signed [DATA_W:0]   reg_a;
    logic signed [DATA_W:0]   reg_m;
    logic        [DATA_W-1:0] reg_q;
    logic                     q_m1;
    logic        [CNT_W-1:0]  step;
    logic                     busy_r;
    logic signed [DATA_W:0]   a_sum;

    always_comb begin
        a_sum = reg_a;
        case ({reg_q[0], q_m1})
            2'b01:   a_sum = reg_a + reg_m;
            2'b10:   a_sum = reg_a - reg_m;
            default: a_sum = reg_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a  <= '0;
            reg_m  <= '0;
            reg_q  <= '0;
            q_m1   <= 1'b0;
            step   <= '0;
            busy_r <= 1'b0;
        end else if (start && !busy_r) begin
            reg_a  <= '0;
            reg_m  <= {a[DATA_W-1], a};
            reg_q  <= b;
            q_m1   <= 1'b0;
            step   <= CNT_W'(DATA_W - 1);
            busy_r <= 1'b1;
        end else if (busy_r) begin
            // Arithmetic shift of {A, Q, q-1} by one place.
            reg_a <= a_sum >>> 1;
            reg_q <= {a_sum[0], reg_q[DATA_W-1:1]};
            q_m1  <= reg_q[0];
            if (step == '0)
                busy_r <= 1'b0;
            else
                step <= step - 1'b1;
        end
    end

    assign busy = busy_r;
    assign done = busy_r && (step == '0);
    assign p    = $signed({reg_a[DATA_W-1:0], reg_q});

endmodule

// File: rtl/neuron_mac_seq.sv
// ---------------------------------------------------------------------------
// neuron_mac_seq
// Accumulates N_INPUTS signed x*w products into a saturating ACC_W-bit sum
// that feeds the adder stage's in2 operand.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input pair handshake
//   x, w                : signed activation / weight
//   acc_out             : accumulated sum, meaningful while out_valid=1
//   out_valid/out_ready : result handshake
//   sat                 : sticky saturation flag for this evaluation
// ---------------------------------------------------------------------------
module neuron_mac_seq #(
    parameter int N_INPUTS = 4,
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] w,
    output logic signed [ACC_W-1:0]  acc_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sat
);
    import neuron_pkg::*;

    state_t                   state;
    state_t                   state_next;
    logic                     run;
    logic [7:0]               count;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum;
    logic                     add_ovf;
    logic                     in_fire;
    logic                     mul_busy;
    logic                     mul_done;
    logic signed [ACC_W-1:0]  mul_p;

    assign in_fire = in_valid && in_ready;

    // The multiplier's operand registers are the x/w capture registers.
    seq_booth_mul #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) u_mul (
        .clk  (clk),
        .rst_n(rst_n),
        .start(in_fire),
        .a    (x),
        .b    (w),
        .busy (mul_busy),
        .done (mul_done),
        .p    (mul_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= WAIT;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT: if (in_fire) state_next = MULT;
            MULT: if (mul_done) state_next = ACC;
            ACC:  state_next = (count == 8'(N_INPUTS - 1)) ? DONE : WAIT;
            DONE: if (out_ready) state_next = WAIT;
            default: state_next = WAIT;
        endcase
    end

    // run holds in_ready low until the first clock edge after reset release.
    always_comb begin
        in_ready  = (state == WAIT) && run && !mul_busy;
        out_valid = (state == DONE);
    end

    always_comb begin
        acc_sum = sat_add(acc, mul_p, add_ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run   <= 1'b0;
            acc   <= '0;
            sat   <= 1'b0;
            count <= '0;
        end else begin
            run <= 1'b1;
            if (state == ACC) begin
                acc   <= acc_sum;
                sat   <= sat | add_ovf;
                count <= count + 8'd1;
            end else if (state == DONE && out_ready) begin
                acc   <= '0;
                sat   <= 1'b0;
                count <= '0;
            end
        end
    end

    assign acc_out = acc;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// ---------------------------------------------------------------------------
// tb_neuron_mac_seq
// Directed bench for neuron_mac_seq with hand-computed expected sums,
// handshake timing, backpressure, input gaps and reset mid-operation.
// ---------------------------------------------------------------------------
module tb_neuron_mac_seq;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [7:0]  x;
    logic signed [7:0]  w;
    logic signed [15:0] acc_out;
    logic               out_valid;
    logic               out_ready;
    logic               sat;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int oc;

    logic signed [7:0] xs [4];
    logic signed [7:0] ws [4];
    int                acc_cyc [4];

    neuron_mac_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .w        (w),
        .acc_out  (acc_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sat      (sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_vec(input logic signed [7:0] x0, input logic signed [7:0] w0,
                           input logic signed [7:0] x1, input logic signed [7:0] w1,
                           input logic signed [7:0] x2, input logic signed [7:0] w2,
                           input logic signed [7:0] x3, input logic signed [7:0] w3);
        xs[0] = x0; ws[0] = w0;
        xs[1] = x1; ws[1] = w1;
        xs[2] = x2; ws[2] = w2;
        xs[3] = x3; ws[3] = w3;
    endtask

    // Offer pairs first..first+cnt-1; gap idle cycles precede every pair
    // after the first. gap=0 keeps in_valid high throughout.
    task automatic send_pairs(input int first, input int cnt, input int gap);
        int budget;
        for (int i = first; i < first + cnt; i++) begin
            if (i != first) begin
                in_valid = 1'b0;
                repeat (gap) tick();
            end
            in_valid = 1'b1;
            x = xs[i];
            w = ws[i];
            budget = 100;
            while (!in_ready && budget > 0) begin
                tick();
                budget--;
            end
            if (budget == 0) chk("accept_timeout", 0, 1);
            acc_cyc[i] = cyc;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int c);
        int budget;
        budget = 200;
        while (!out_valid && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) chk("out_valid_timeout", 0, 1);
        c = cyc;
    endtask

    task automatic run_eval(input string tag, input logic signed [63:0] exp_acc,
                            input logic exp_sat);
        send_pairs(0, 4, 0);
        wait_out(oc);
        chk({tag, "_acc"}, acc_out, exp_acc);
        chk({tag, "_sat"}, sat, exp_sat);
        tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        x         = '0;
        w         = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_acc_out", acc_out, 0);
        chk("rst_sat", sat, 0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", in_ready, 1);

        // Basic sum: 2 + 12 + 30 + 56 = 100
        set_vec(8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8);
        send_pairs(0, 4, 0);
        wait_out(oc);
        chk("basic_accept1", acc_cyc[1] - acc_cyc[0], 10);
        chk("basic_accept2", acc_cyc[2] - acc_cyc[0], 20);
        chk("basic_accept3", acc_cyc[3] - acc_cyc[0], 30);
        chk("basic_out_cycle", oc - acc_cyc[0], 40);
        chk("basic_acc", acc_out, 100);
        chk("basic_sat", sat, 0);
        chk("basic_ready_in_done", in_ready, 0);
        tick();
        chk("basic_out_valid_clr", out_valid, 0);
        chk("basic_ready_back", in_ready, 1);

        // Sign coverage: -35 - 18 + 16 + 0 = -37
        set_vec(-8'sd5, 8'sd7, 8'sd6, -8'sd3, -8'sd4, -8'sd4, 8'sd0, 8'sd127);
        run_eval("sign", -37, 0);

        // Largest single product in isolation
        set_vec(-8'sd128, -8'sd128, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0);
        run_eval("prod_max", 16384, 0);

        // Positive saturation: 16384, 32768 -> clamp, stays clamped
        set_vec(-8'sd128, -8'sd128, -8'sd128, -8'sd128,
                -8'sd128, -8'sd128, -8'sd128, -8'sd128);
        run_eval("pos_sat", 32767, 1);

        // Negative saturation: -16256, -32512, -48768 -> clamp
        set_vec(8'sd127, -8'sd128, 8'sd127, -8'sd128,
                8'sd127, -8'sd128, 8'sd127, -8'sd128);
        run_eval("neg_sat", -32768, 1);

        // Backpressure on a saturated result
        out_ready = 1'b0;
        set_vec(-8'sd128, -8'sd128, -8'sd128, -8'sd128,
                -8'sd128, -8'sd128, -8'sd128, -8'sd128);
        send_pairs(0, 4, 0);
        wait_out(oc);
        for (int k = 0; k < 5; k++) begin
            chk("bp_acc_hold", acc_out, 32767);
            chk("bp_sat_hold", sat, 1);
            chk("bp_valid_hold", out_valid, 1);
            chk("bp_ready_low", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_valid_clr", out_valid, 0);
        chk("bp_ready_back", in_ready, 1);
        chk("bp_sat_clr", sat, 0);
        chk("bp_acc_clr", acc_out, 0);

        // Gapped input: 12 idle cycles before each later pair
        set_vec(8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8);
        send_pairs(0, 4, 12);
        wait_out(oc);
        chk("gap_accept1", acc_cyc[1] - acc_cyc[0], 13);
        chk("gap_accept2", acc_cyc[2] - acc_cyc[0], 26);
        chk("gap_accept3", acc_cyc[3] - acc_cyc[0], 39);
        chk("gap_out_cycle", oc - acc_cyc[0], 49);
        chk("gap_acc", acc_out, 100);
        chk("gap_sat", sat, 0);
        tick();

        // Reset during the third multiplication
        send_pairs(0, 3, 0);
        tick();
        tick();
        chk("abort_partial", acc_out, 14);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_acc", acc_out, 0);
        chk("abort_sat", sat, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        send_pairs(0, 4, 0);
        wait_out(oc);
        chk("rerun_out_cycle", oc - acc_cyc[0], 40);
        chk("rerun_acc", acc_out, 100);
        chk("rerun_sat", sat, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
